sc130gs_i2c_lut_writer: RTL and testbench
=========================================

Name: sc130gs_i2c_lut_writer

Overview:
- Consumer of the SC130GS register-configuration LUT. Steps the LUT index from 0 to lut_size-1 and, for each entry, performs one I2C write on the sensor bus: START, slave address + W, register address MSB, register address LSB, data byte, STOP.
- Asserts config_done when every entry has been written.
- Sits between the sensor-config LUT and the open-drain SCL/SDA pads.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- I2C_FREQ, 100_000, SCL frequency in Hz. Quarter-bit divider QDIV = CLK_FREQ/(4*I2C_FREQ) clock cycles; QDIV must be >= 2.
- SLAVE_ADDR, 8'h60, 8-bit write address of the sensor (7-bit 0x30 shifted left, R/W bit = 0).
- PWR_DELAY, 20_000, clock cycles to wait after reset release before the first transfer.
- SRST_DELAY, 5_000, clock cycles to wait after the transfer that writes register 16'h0103 (soft reset).
- MAX_RETRY, 3, retries allowed per entry on NACK before the entry is skipped.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- lut_index  out  8  index presented to the config LUT.
- lut_data  in  24  {reg_addr[15:0], reg_data[7:0]}; valid combinationally for the current lut_index.
- lut_size  in  8  number of LUT entries.
- i2c_sclk  out  1  SCL (push-pull).
- i2c_sdat_oe  out  1  1 = pull SDA low, 0 = release SDA.
- i2c_sdat_i  in  1  sampled SDA pad value.
- busy  out  1  high while a transfer or delay is in progress.
- config_done  out  1  sticky high after the last entry is finished.
- ack_err  out  1  sticky high if any entry was skipped after exhausting its retries.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- Reset values: lut_index=0, i2c_sclk=1, i2c_sdat_oe=0, busy=0, config_done=0, ack_err=0, state=PWR_WAIT, retry counter=0. Asserting rst mid-transfer abandons the transfer immediately and the bus is released.
- Quarter tick: a strobe every QDIV clocks, produced by a free-running counter. All bus-phase state changes occur only on a tick.
- Bit cell = 4 ticks:
  - q0: SCL low, drive SDA.
  - q1: SCL high.
  - q2: SCL high; SDA sampled at the end of q2.
  - q3: SCL low.
- START cell: SDA released with SCL high, then SDA pulled low while SCL is high, then SCL low.
- STOP cell: SDA low, SCL rises, then SDA released while SCL is high.
- Bytes are sent MSB first. The ACK slot releases SDA; ACK = sample 0.
- FSM states:
  - PWR_WAIT: count PWR_DELAY clocks, then go to LOAD.
  - LOAD: if lut_index >= lut_size, go to DONE. Otherwise latch lut_data into a 24-bit shadow register, set byte counter = 0, go to START. lut_data is not sampled again during the transfer.
  - START: go to TX_BYTE.
  - TX_BYTE: bytes in order: SLAVE_ADDR, shadow[23:16], shadow[15:8], shadow[7:0]. 8 bit cells, then go to ACK.
  - ACK: on ACK, advance to the next byte; after byte 3 go to STOP. On NACK, go to STOP with the nack flag set.
  - STOP: go to NEXT.
  - NEXT:
    - nack set and retry < MAX_RETRY: retry+1, go to LOAD with the same index.
    - nack set and retry == MAX_RETRY: set ack_err, clear retry, increment index.
    - no nack: clear retry, increment index.
    - Then go to SRST_WAIT if shadow[23:8]==16'h0103 and the write succeeded; otherwise go to LOAD.
  - SRST_WAIT: count SRST_DELAY clocks, then go to LOAD.
  - DONE: config_done=1, bus idle (SCL=1, SDA released), busy=0. Remain here until reset.
- busy=1 in all states except PWR_WAIT and DONE.
- lut_size=0: the block goes straight from LOAD to DONE; no bus activity.
- lut_index is 8 bits and increments saturate at 255. Entries past lut_size are never read.

Test Plan:
- Common setup: CLK_FREQ=4_000_000, I2C_FREQ=100_000 (QDIV=10), PWR_DELAY=100, SRST_DELAY=50, model slave always ACKs, 3-entry LUT {0103,01}, {3e01,40}, {0100,01}.
- Nominal run: observed bytes 60 01 03 01, 60 3e 01 40, 60 01 00 01. Each bit cell is 40 clocks. SRST_WAIT of 50 clocks occurs only after entry 0. config_done rises after the third STOP; ack_err=0.
- Reset: SCL/SDA idle, busy=0 during PWR_WAIT. The first SCL falling edge occurs no earlier than 100 clocks after rst deasserts.
- NACK retry: slave NACKs the register-MSB byte of entry 1 twice, then ACKs. Entry 1 is transmitted 3 times in total, index advances, ack_err=0.
- Persistent NACK: slave never ACKs entry 1. Exactly 4 attempts occur, then entry 2 is written, ack_err=1, config_done=1.
- Mid-transfer reset: assert rst during the data byte of entry 1. SCL goes to 1 and SDA is released the same cycle, lut_index=0, and the sequence restarts from PWR_WAIT.
- Empty LUT: lut_size=0 gives config_done=1 with no SCL transitions after PWR_WAIT.

Source files
------------

// File: rtl/sc130gs_i2c_lut_writer.sv
// SC130GS configuration writer: walks the register LUT and issues one
// I2C write (addr+W, reg MSB, reg LSB, data) per entry on the sensor bus.
// NACKed entries are retried; a soft-reset register write is followed by
// a settling delay before the next entry.
module sc130gs_i2c_lut_writer #(
  parameter int         CLK_FREQ   = 25_000_000,
  parameter int         I2C_FREQ   = 100_000,
  parameter logic [7:0] SLAVE_ADDR = 8'h60,
  parameter int         PWR_DELAY  = 20_000,
  parameter int         SRST_DELAY = 5_000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  input  logic [7:0]  lut_size,
  output logic        i2c_sclk,
  output logic        i2c_sdat_oe,
  input  logic        i2c_sdat_i,
  output logic        busy,
  output logic        config_done,
  output logic        ack_err
);

  localparam int          QDIV      = CLK_FREQ / (4 * I2C_FREQ);
  localparam logic [15:0] QLAST     = 16'(QDIV - 1);
  localparam logic [31:0] PWR_LAST  = 32'(PWR_DELAY - 1);
  localparam logic [31:0] SRST_LAST = 32'(SRST_DELAY - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    PWR_WAIT  = 4'd0,
    LOAD      = 4'd1,
    START     = 4'd2,
    TX_BYTE   = 4'd3,
    ACK       = 4'd4,
    STOP      = 4'd5,
    NEXT      = 4'd6,
    SRST_WAIT = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t      state_r, state_nxt;
  logic [15:0] qcnt_r;
  logic        tick_s;
  logic [31:0] dly_r, dly_nxt;
  logic [1:0]  phase_r, phase_nxt;
  logic [2:0]  bit_r, bit_nxt;
  logic [1:0]  byte_r, byte_nxt;
  logic [23:0] shadow_r, shadow_nxt;
  logic        nack_r, nack_nxt;
  logic [7:0]  retry_r, retry_nxt;
  logic [7:0]  index_r, index_nxt;
  logic        ack_err_r, ack_err_nxt;
  logic        scl_r, scl_nxt;
  logic        oe_r, oe_nxt;
  logic        busy_r, busy_nxt;
  logic        done_r, done_nxt;
  logic [7:0]  tx_byte_s;
  logic [7:0]  tx_shift_s;

  assign tick_s      = (qcnt_r == QLAST);
  assign lut_index   = index_r;
  assign i2c_sclk    = scl_r;
  assign i2c_sdat_oe = oe_r;
  assign busy        = busy_r;
  assign config_done = done_r;
  assign ack_err     = ack_err_r;

  // Free-running quarter-bit divider producing the bus tick strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt_r <= 16'd0;
    end else if (qcnt_r == QLAST) begin
      qcnt_r <= 16'd0;
    end else begin
      qcnt_r <= qcnt_r + 16'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= PWR_WAIT;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_nxt   = state_r;
    dly_nxt     = dly_r;
    phase_nxt   = phase_r;
    bit_nxt     = bit_r;
    byte_nxt    = byte_r;
    shadow_nxt  = shadow_r;
    nack_nxt    = nack_r;
    retry_nxt   = retry_r;
    index_nxt   = index_r;
    ack_err_nxt = ack_err_r;
    case (state_r)
      PWR_WAIT: begin
        if (dly_r == PWR_LAST) begin
          dly_nxt   = 32'd0;
          state_nxt = LOAD;
        end else begin
          dly_nxt = dly_r + 32'd1;
        end
      end
      LOAD: begin
        // Wait for a tick so the START cell begins on a quarter boundary
        if (tick_s) begin
          if (index_r >= lut_size) begin
            state_nxt = DONE;
          end else begin
            shadow_nxt = lut_data;
            byte_nxt   = 2'd0;
            bit_nxt    = 3'd0;
            phase_nxt  = 2'd0;
            nack_nxt   = 1'b0;
            state_nxt  = START;
          end
        end else begin
          state_nxt = LOAD;
        end
      end
      START: begin
        if (tick_s) begin
          if (phase_r == 2'd3) begin
            phase_nxt = 2'd0;
            bit_nxt   = 3'd0;
            state_nxt = TX_BYTE;
          end else begin
            phase_nxt = phase_r + 2'd1;
          end
        end else begin
          state_nxt = START;
        end
      end
      TX_BYTE: begin
        if (tick_s) begin
          if (phase_r == 2'd3) begin
            phase_nxt = 2'd0;
            if (bit_r == 3'd7) begin
              bit_nxt   = 3'd0;
              state_nxt = ACK;
            end else begin
              bit_nxt = bit_r + 3'd1;
            end
          end else begin
            phase_nxt = phase_r + 2'd1;
          end
        end else begin
          state_nxt = TX_BYTE;
        end
      end
      ACK: begin
        if (tick_s) begin
          if (phase_r == 2'd3) begin
            phase_nxt = 2'd0;
            if (nack_r || (byte_r == 2'd3)) begin
              state_nxt = STOP;
            end else begin
              byte_nxt  = byte_r + 2'd1;
              state_nxt = TX_BYTE;
            end
          end else begin
            phase_nxt = phase_r + 2'd1;
            // SDA is sampled at the end of q2; a released line is a NACK
            if (phase_r == 2'd2) begin
              nack_nxt = i2c_sdat_i;
            end else begin
              nack_nxt = nack_r;
            end
          end
        end else begin
          state_nxt = ACK;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (phase_r == 2'd3) begin
            phase_nxt = 2'd0;
            state_nxt = NEXT;
          end else begin
            phase_nxt = phase_r + 2'd1;
          end
        end else begin
          state_nxt = STOP;
        end
      end
      NEXT: begin
        if (nack_r && (retry_r < RETRY_MAX)) begin
          retry_nxt = retry_r + 8'd1;
          state_nxt = LOAD;
        end else begin
          if (nack_r) begin
            ack_err_nxt = 1'b1;
          end else begin
            ack_err_nxt = ack_err_r;
          end
          retry_nxt = 8'd0;
          if (index_r != 8'hFF) begin
            index_nxt = index_r + 8'd1;
          end else begin
            index_nxt = index_r;
          end
          // Sensor needs settling time after a successful soft reset write
          if (!nack_r && (shadow_r[23:8] == 16'h0103)) begin
            state_nxt = SRST_WAIT;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      SRST_WAIT: begin
        if (dly_r == SRST_LAST) begin
          dly_nxt   = 32'd0;
          state_nxt = LOAD;
        end else begin
          dly_nxt = dly_r + 32'd1;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = PWR_WAIT;
      end
    endcase
  end

  // Byte currently being shifted out
  always_comb begin
    tx_byte_s = SLAVE_ADDR;
    case (byte_nxt)
      2'd0:    tx_byte_s = SLAVE_ADDR;
      2'd1:    tx_byte_s = shadow_nxt[23:16];
      2'd2:    tx_byte_s = shadow_nxt[15:8];
      2'd3:    tx_byte_s = shadow_nxt[7:0];
      default: tx_byte_s = SLAVE_ADDR;
    endcase
    tx_shift_s = tx_byte_s << bit_nxt;
  end

  // Bus levels and status flags decoded from the upcoming state and quarter
  always_comb begin
    scl_nxt = 1'b1;
    oe_nxt  = 1'b0;
    case (state_nxt)
      START: begin
        scl_nxt = (phase_nxt != 2'd3);
        oe_nxt  = (phase_nxt != 2'd0);
      end
      TX_BYTE: begin
        scl_nxt = (phase_nxt == 2'd1) || (phase_nxt == 2'd2);
        oe_nxt  = ~tx_shift_s[7];
      end
      ACK: begin
        scl_nxt = (phase_nxt == 2'd1) || (phase_nxt == 2'd2);
        oe_nxt  = 1'b0;
      end
      STOP: begin
        scl_nxt = (phase_nxt != 2'd0);
        oe_nxt  = (phase_nxt != 2'd3);
      end
      default: begin
        scl_nxt = 1'b1;
        oe_nxt  = 1'b0;
      end
    endcase
    busy_nxt = !((state_nxt == PWR_WAIT) || (state_nxt == DONE));
    done_nxt = (state_nxt == DONE);
  end

  // Datapath and registered bus/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_r     <= 32'd0;
      phase_r   <= 2'd0;
      bit_r     <= 3'd0;
      byte_r    <= 2'd0;
      shadow_r  <= 24'd0;
      nack_r    <= 1'b0;
      retry_r   <= 8'd0;
      index_r   <= 8'd0;
      ack_err_r <= 1'b0;
      scl_r     <= 1'b1;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      dly_r     <= dly_nxt;
      phase_r   <= phase_nxt;
      bit_r     <= bit_nxt;
      byte_r    <= byte_nxt;
      shadow_r  <= shadow_nxt;
      nack_r    <= nack_nxt;
      retry_r   <= retry_nxt;
      index_r   <= index_nxt;
      ack_err_r <= ack_err_nxt;
      scl_r     <= scl_nxt;
      oe_r      <= oe_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sc130gs_i2c_lut_writer.sv
// Bench for sc130gs_i2c_lut_writer: an I2C slave model decodes the bus,
// a scoreboard queue holds the expected byte stream for each scenario.
module tb_sc130gs_i2c_lut_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  lut_index;
  logic [23:0] lut_data;
  logic [7:0]  lut_size;
  logic        i2c_sclk;
  logic        i2c_sdat_oe;
  logic        i2c_sdat_i;
  logic        busy;
  logic        config_done;
  logic        ack_err;

  logic        slave_pull = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  logic [7:0]  sb_q[$];

  // slave-model / monitor state
  int          mon_bitcnt = 0;
  int          mon_bytecnt = 0;
  int          frame_cnt = 0;
  int          scl_edges = 0;
  int          first_fall = -1;
  int          nack_budget = 0;
  int          start_cyc[$];
  int          stop_cyc[$];

  sc130gs_i2c_lut_writer #(
    .CLK_FREQ  (4_000_000),
    .I2C_FREQ  (100_000),
    .SLAVE_ADDR(8'h60),
    .PWR_DELAY (100),
    .SRST_DELAY(50),
    .MAX_RETRY (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lut_index  (lut_index),
    .lut_data   (lut_data),
    .lut_size   (lut_size),
    .i2c_sclk   (i2c_sclk),
    .i2c_sdat_oe(i2c_sdat_oe),
    .i2c_sdat_i (i2c_sdat_i),
    .busy       (busy),
    .config_done(config_done),
    .ack_err    (ack_err)
  );

  // open-drain SDA: low if either side pulls
  assign i2c_sdat_i = ~(i2c_sdat_oe | slave_pull);

  // configuration LUT
  always_comb begin
    lut_data = 24'h000000;
    case (lut_index)
      8'd0:    lut_data = 24'h010301;
      8'd1:    lut_data = 24'h3e0140;
      8'd2:    lut_data = 24'h010001;
      default: lut_data = 24'h000000;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_entry(input logic [23:0] e);
    sb_q.push_back(8'h60);
    sb_q.push_back(e[23:16]);
    sb_q.push_back(e[15:8]);
    sb_q.push_back(e[7:0]);
  endtask

  task automatic push_nack_attempt();
    sb_q.push_back(8'h60);
    sb_q.push_back(8'h3e);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (config_done) break;
    end
    check(name, config_done, 1);
  endtask

  // Monitor / slave model: decodes START, STOP and bytes, answers ACK slots
  initial begin : monitor
    logic scl, sda, pscl, psda, in_frame, have_rise, ack;
    logic [7:0] shreg;
    int last_rise;
    pscl = 1'b1; psda = 1'b1; in_frame = 1'b0; have_rise = 1'b0;
    shreg = 8'h00; last_rise = 0;
    forever begin
      @(negedge clk);
      scl = i2c_sclk;
      sda = i2c_sdat_i;
      if (rst) begin
        pscl = 1'b1; psda = 1'b1; in_frame = 1'b0; have_rise = 1'b0;
        mon_bitcnt = 0; mon_bytecnt = 0; frame_cnt = 0; scl_edges = 0;
        first_fall = -1; slave_pull = 1'b0;
        start_cyc.delete();
        stop_cyc.delete();
      end else begin
        if (scl != pscl) scl_edges++;
        if (pscl && !scl && (first_fall < 0)) first_fall = cyc;
        if (pscl && scl && psda && !sda) begin
          frame_cnt++;
          start_cyc.push_back(cyc);
          in_frame = 1'b1; have_rise = 1'b0;
          mon_bitcnt = 0; mon_bytecnt = 0; slave_pull = 1'b0;
        end else if (pscl && scl && !psda && sda) begin
          stop_cyc.push_back(cyc);
          in_frame = 1'b0; have_rise = 1'b0; mon_bitcnt = 0;
        end else if (in_frame && !pscl && scl) begin
          if (have_rise) check("bit_cell_clocks", cyc - last_rise, 40);
          have_rise = 1'b1;
          last_rise = cyc;
          if (mon_bitcnt < 8) shreg = {shreg[6:0], sda};
          mon_bitcnt++;
        end else if (in_frame && pscl && !scl) begin
          if (mon_bitcnt == 8) begin
            ack = 1'b1;
            if ((mon_bytecnt == 1) && (shreg == 8'h3e) && (nack_budget > 0)) begin
              ack = 1'b0;
              nack_budget--;
            end
            slave_pull = ack;
          end else if (mon_bitcnt == 9) begin
            slave_pull = 1'b0;
            if (sb_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL byte_unexpected: got 0x%0h expected no byte", shreg);
            end else begin
              check("bus_byte", shreg, sb_q.pop_front());
            end
            mon_bytecnt++;
            mon_bitcnt = 0;
          end
        end
        pscl = scl;
        psda = sda;
      end
    end
  end

  initial begin : stimulus
    logic found;
    rst = 1'b1;
    lut_size = 8'd3;

    // ---------------- nominal run with reset / power-up checks
    nack_budget = 0;
    push_entry(24'h010301);
    push_entry(24'h3e0140);
    push_entry(24'h010001);
    repeat (3) @(negedge clk);
    check("rst_sclk", i2c_sclk, 1);
    check("rst_sda_oe", i2c_sdat_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", config_done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_index", lut_index, 0);
    apply_reset();
    repeat (50) @(negedge clk);
    check("pwr_sclk", i2c_sclk, 1);
    check("pwr_sda_oe", i2c_sdat_oe, 0);
    check("pwr_busy", busy, 0);
    wait_done("nom_done");
    check("nom_first_fall_ge_100", (first_fall - rel_cyc) >= 100, 1);
    check("nom_ack_err", ack_err, 0);
    check("nom_busy", busy, 0);
    check("nom_index", lut_index, 3);
    check("nom_sb_empty", sb_q.size(), 0);
    check("nom_frames", frame_cnt, 3);
    check("nom_stops", stop_cyc.size(), 3);
    if ((start_cyc.size() == 3) && (stop_cyc.size() == 3)) begin
      check("nom_gap_srst", (start_cyc[1] - stop_cyc[0]) >= 60, 1);
      check("nom_gap_plain", (start_cyc[2] - stop_cyc[1]) <= 40, 1);
    end
    repeat (100) @(negedge clk);
    check("nom_idle_sclk", i2c_sclk, 1);
    check("nom_idle_sda", i2c_sdat_oe, 0);

    // ---------------- NACK twice on entry 1 register MSB
    sb_q.delete();
    nack_budget = 2;
    push_entry(24'h010301);
    push_nack_attempt();
    push_nack_attempt();
    push_entry(24'h3e0140);
    push_entry(24'h010001);
    apply_reset();
    wait_done("retry_done");
    check("retry_ack_err", ack_err, 0);
    check("retry_index", lut_index, 3);
    check("retry_frames", frame_cnt, 5);
    check("retry_sb_empty", sb_q.size(), 0);

    // ---------------- persistent NACK on entry 1
    sb_q.delete();
    nack_budget = 1000;
    push_entry(24'h010301);
    for (int i = 0; i < 4; i++) push_nack_attempt();
    push_entry(24'h010001);
    apply_reset();
    wait_done("pnack_done");
    check("pnack_ack_err", ack_err, 1);
    check("pnack_index", lut_index, 3);
    check("pnack_frames", frame_cnt, 6);
    check("pnack_sb_empty", sb_q.size(), 0);

    // ---------------- reset during entry 1 data byte
    sb_q.delete();
    nack_budget = 0;
    push_entry(24'h010301);
    sb_q.push_back(8'h60);
    sb_q.push_back(8'h3e);
    sb_q.push_back(8'h01);
    push_entry(24'h010301);
    push_entry(24'h3e0140);
    push_entry(24'h010001);
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ((frame_cnt == 2) && (mon_bytecnt == 3) && (mon_bitcnt == 4)) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_trigger", found, 1);
    check("midrst_index_before", lut_index, 1);
    check("midrst_busy_before", busy, 1);
    #3 rst = 1'b1;
    #1;
    check("midrst_sclk", i2c_sclk, 1);
    check("midrst_sda_oe", i2c_sdat_oe, 0);
    check("midrst_index", lut_index, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
    wait_done("midrst_done");
    check("midrst_first_fall_ge_100", (first_fall - rel_cyc) >= 100, 1);
    check("midrst_ack_err", ack_err, 0);
    check("midrst_index_end", lut_index, 3);
    check("midrst_sb_empty", sb_q.size(), 0);

    // ---------------- empty LUT
    sb_q.delete();
    lut_size = 8'd0;
    apply_reset();
    wait_done("empty_done");
    repeat (200) @(negedge clk);
    check("empty_scl_edges", scl_edges, 0);
    check("empty_frames", frame_cnt, 0);
    check("empty_busy", busy, 0);
    check("empty_ack_err", ack_err, 0);
    check("empty_index", lut_index, 0);
    check("empty_done_sticky", config_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
